led_scan_controller: RTL

Sequencer for the shared seven-segment decoder. It holds a 4-character message, accepted one code at a time over a valid/ready handshake, as a right-entering marquee. It time-multiplexes the one decoder across four common-anode digits by driving the 4-bit character code and the active-low digit enables. It sits between the receiver's character output and the decoder input.

---
 rtl/led_scan_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/led_scan_controller.sv
// rtl/led_scan_controller.sv - marquee message store and 4-digit multiplexed scan for a shared 7-segment decoder
module led_scan_controller #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic       clear,
   output logic [3:0] char_out,
   output logic [3:0] an,
   output logic       bad_char
);

   localparam logic [15:0] CNT_MAX = 16'(REFRESH_DIV - 1);
   localparam logic [3:0]  SPACE   = 4'b1100;
   localparam logic [3:0]  DASH    = 4'b1010;

   typedef enum logic [2:0] {SCAN, CLR0, CLR1, CLR2, CLR3} state_t;

   state_t           state_q, state_d;
   logic [3:0][3:0]  digit_q, digit_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       char_out_q, char_out_d;
   logic             bad_q, bad_d;

   logic             clr_en;
   logic [1:0]       clr_idx;
   logic             xfer;
   logic             code_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= SCAN;
         digit_q    <= {4{SPACE}};
         cnt_q      <= '0;
         idx_q      <= '0;
         an_q       <= 4'b1111;
         char_out_q <= SPACE;
         bad_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         digit_q    <= digit_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         char_out_q <= char_out_d;
         bad_q      <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN:    if (clear) state_d = CLR0;
         CLR0:    state_d = CLR1;
         CLR1:    state_d = CLR2;
         CLR2:    state_d = CLR3;
         CLR3:    state_d = SCAN;
         default: state_d = SCAN;
      endcase
   end

   // Clear walks one digit per cycle; the store is locked out until it is done.
   always_comb begin
      char_ready = 1'b0;
      clr_en     = 1'b0;
      clr_idx    = 2'd0;
      case (state_q)
         SCAN:    char_ready = !clear;
         CLR0:    begin clr_en = 1'b1; clr_idx = 2'd0; end
         CLR1:    begin clr_en = 1'b1; clr_idx = 2'd1; end
         CLR2:    begin clr_en = 1'b1; clr_idx = 2'd2; end
         CLR3:    begin clr_en = 1'b1; clr_idx = 2'd3; end
         default: char_ready = 1'b0;
      endcase
   end

   always_comb begin
      xfer     = char_valid && char_ready;
      code_bad = char_in > SPACE;
      digit_d  = digit_q;
      if (xfer) begin
         digit_d = {digit_q[2:0], code_bad ? DASH : char_in};
      end else if (clr_en) begin
         digit_d[clr_idx] = SPACE;
      end
      bad_d = xfer && code_bad;
   end

   // Scan runs free of the FSM; outputs reflect the stored contents before this edge.
   always_comb begin
      cnt_d      = (cnt_q == CNT_MAX) ? 16'd0 : cnt_q + 16'd1;
      idx_d      = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
      an_d       = ~(4'b0001 << idx_q);
      char_out_d = digit_q[idx_q];
   end

   assign char_out = char_out_q;
   assign an       = an_q;
   assign bad_char = bad_q;

endmodule
